// File: rtl/maj11_bist.sv
// Exhaustive-sweep BIST for an N-input majority/threshold circuit.
// Latency: one vector per SETTLE+1 cycles; a full run takes 2^N*(SETTLE+1) cycles.
// Backpressure: none; start is only honoured in IDLE/DONE, and is ignored while busy.
//
// Ports:
//   clk, rst          - single clock, synchronous active-high reset
//   start             - one-cycle run request (IDLE/DONE only)
//   vec_o             - stimulus vector to the DUT, bit i drives xi
//   dut_y_i           - DUT output under test
//   ref_o             - combinational reference: popcount(vec_o) >= THRESH
//   busy, done, pass  - run status; pass = done && no mismatches
//   err_count         - mismatch count of the current/last run (N+1 bits, no wrap)
//   first_fail_valid  - at least one mismatch recorded
//   first_fail_vec    - lowest vector that mismatched
module maj11_bist #(
  parameter int N      = 11,
  parameter int THRESH = 6,
  parameter int SETTLE = 1   // legal range 1..15 (settle counter is 4 bits)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic [N-1:0] vec_o,
  input  logic         dut_y_i,
  output logic         ref_o,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_count,
  output logic         first_fail_valid,
  output logic [N-1:0] first_fail_vec
);

  localparam int          CW        = $clog2(N + 1);
  localparam logic [3:0]  SETTLE_LD = 4'(SETTLE - 1);
  localparam logic [31:0] THRESH_U  = 32'(THRESH);
  localparam logic [N-1:0] VEC_LAST = {N{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] vec_q, vec_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [N:0]   err_q, err_d;
  logic         ffv_q, ffv_d;
  logic [N-1:0] ffvec_q, ffvec_d;

  // Population count sized to hold N without overflow.
  logic [CW-1:0] pop;
  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) begin
      pop = pop + CW'(vec_q[i]);
    end
  end

  assign ref_o = ({{(32 - CW){1'b0}}, pop} >= THRESH_U);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffvec_d = ffvec_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          vec_d   = '0;
          err_d   = '0;
          ffv_d   = 1'b0;
          ffvec_d = '0;
          cnt_d   = SETTLE_LD;
          state_d = S_SETTLE;
        end
      end

      S_SETTLE: begin
        // Counter is loaded with SETTLE-1, so this state lasts SETTLE cycles.
        if (cnt_q == 4'd0) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_CHECK: begin
        if (dut_y_i != ref_o) begin
          err_d = err_q + {{N{1'b0}}, 1'b1};
          // Sweep is ascending, so the first recorded failure is the lowest one.
          if (!ffv_q) begin
            ffv_d   = 1'b1;
            ffvec_d = vec_q;
          end
        end
        if (vec_q == VEC_LAST) begin
          state_d = S_DONE;   // vec_o holds at all-ones; no wrap
        end else begin
          vec_d   = vec_q + {{(N - 1){1'b0}}, 1'b1};
          cnt_d   = SETTLE_LD;
          state_d = S_SETTLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      ffv_q   <= 1'b0;
      ffvec_q <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffvec_q <= ffvec_d;
    end
  end

  assign vec_o            = vec_q;
  assign busy             = (state_q == S_SETTLE) || (state_q == S_CHECK);
  assign done             = (state_q == S_DONE);
  assign pass             = done && (err_q == '0);
  assign err_count        = err_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;

endmodule

// File: tb/tb_maj11_bist.sv
// Bench for maj11_bist: directed runs against good, stuck-at-0, inverted and
// pipelined majority models, plus restart, ignored-start and mid-run reset cases.
module tb_maj11_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_a;
  logic       start_bc;
  logic [1:0] mode;   // 0 good, 1 stuck-at-0, 2 inverted

  // Instance A: SETTLE=1, combinational DUT model selected by mode
  logic [10:0] vec_a, ffvec_a;
  logic        y_a, ref_a, busy_a, done_a, pass_a, ffv_a;
  logic [11:0] err_a;
  // Instance B: SETTLE=3, 3-stage pipelined good majority
  logic [10:0] vec_b, ffvec_b;
  logic        y_b, ref_b, busy_b, done_b, pass_b, ffv_b;
  logic [11:0] err_b;
  // Instance C: SETTLE=1, same 3-stage pipelined majority
  logic [10:0] vec_c, ffvec_c;
  logic        y_c, ref_c, busy_c, done_c, pass_c, ffv_c;
  logic [11:0] err_c;

  int checks   = 0;
  int failures = 0;
  int excl_viol = 0;

  function automatic logic maj(input logic [10:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 11; i++) c += int'(v[i]);
    return (c >= 6);
  endfunction

  assign y_a = (mode == 2'd0) ? maj(vec_a) :
               (mode == 2'd1) ? 1'b0 : ~maj(vec_a);

  logic [2:0] p_b = 3'b000;
  logic [2:0] p_c = 3'b000;
  always @(posedge clk) begin
    p_b <= {p_b[1:0], maj(vec_b)};
    p_c <= {p_c[1:0], maj(vec_c)};
  end
  assign y_b = p_b[2];
  assign y_c = p_c[2];

  maj11_bist #(.N(11), .THRESH(6), .SETTLE(1)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .vec_o(vec_a), .dut_y_i(y_a),
    .ref_o(ref_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .first_fail_valid(ffv_a), .first_fail_vec(ffvec_a)
  );

  maj11_bist #(.N(11), .THRESH(6), .SETTLE(3)) u_b (
    .clk(clk), .rst(rst), .start(start_bc), .vec_o(vec_b), .dut_y_i(y_b),
    .ref_o(ref_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .first_fail_valid(ffv_b), .first_fail_vec(ffvec_b)
  );

  maj11_bist #(.N(11), .THRESH(6), .SETTLE(1)) u_c (
    .clk(clk), .rst(rst), .start(start_bc), .vec_o(vec_c), .dut_y_i(y_c),
    .ref_o(ref_c), .busy(busy_c), .done(done_c), .pass(pass_c),
    .err_count(err_c), .first_fail_valid(ffv_c), .first_fail_vec(ffvec_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until instance A reports done (or the bound expires); n counts edges.
  task automatic wait_done_a(input int bound, inout int n);
    while (n < bound) begin
      tick();
      n++;
      if (busy_a && done_a) excl_viol++;
      if (done_a) break;
    end
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  int n;
  int nb, nc;

  initial begin
    rst      = 1'b1;
    start_a  = 1'b0;
    start_bc = 1'b0;
    mode     = 2'd0;
    tick();
    tick();
    tick();

    // Reset state (rst still held)
    check("rst_busy",  32'(busy_a), 32'd0);
    check("rst_done",  32'(done_a), 32'd0);
    check("rst_pass",  32'(pass_a), 32'd0);
    check("rst_vec",   32'(vec_a),  32'd0);
    check("rst_err",   32'(err_a),  32'd0);
    check("rst_ffv",   32'(ffv_a),  32'd0);
    check("rst_ffvec", 32'(ffvec_a), 32'd0);
    check("rst_ref",   32'(ref_a),  32'd0);
    rst = 1'b0;
    tick();

    // Run 1: good DUT
    mode = 2'd0;
    pulse_start_a();
    check("r1_busy_after_start", 32'(busy_a), 32'd1);
    n = 0;
    repeat (124) begin tick(); n++; end
    check("r1_vec_at_124", 32'(vec_a), 32'h03E);   // popcount 5
    check("r1_ref_3e",     32'(ref_a), 32'd0);
    repeat (2) begin tick(); n++; end
    check("r1_vec_at_126", 32'(vec_a), 32'h03F);   // popcount 6
    check("r1_ref_3f",     32'(ref_a), 32'd1);
    wait_done_a(5000, n);
    check("r1_cycles", 32'(n),      32'd4096);
    check("r1_done",   32'(done_a), 32'd1);
    check("r1_busy",   32'(busy_a), 32'd0);
    check("r1_pass",   32'(pass_a), 32'd1);
    check("r1_err",    32'(err_a),  32'd0);
    check("r1_ffv",    32'(ffv_a),  32'd0);
    check("r1_vec",    32'(vec_a),  32'h7FF);
    repeat (5) tick();
    check("r1_hold_vec",  32'(vec_a),  32'h7FF);
    check("r1_hold_done", 32'(done_a), 32'd1);

    // Run 2: stuck-at-0, started from DONE
    mode = 2'd1;
    pulse_start_a();
    check("r2_busy_after_start", 32'(busy_a), 32'd1);
    check("r2_done_after_start", 32'(done_a), 32'd0);
    n = 0;
    wait_done_a(5000, n);
    check("r2_cycles", 32'(n),       32'd4096);
    check("r2_err",    32'(err_a),   32'd1024);
    check("r2_ffv",    32'(ffv_a),   32'd1);
    check("r2_ffvec",  32'(ffvec_a), 32'h03F);
    check("r2_pass",   32'(pass_a),  32'd0);

    // Run 3: inverted; start from DONE must clear previous results
    mode = 2'd2;
    pulse_start_a();
    check("r3_clr_err",   32'(err_a),   32'd0);
    check("r3_clr_ffv",   32'(ffv_a),   32'd0);
    check("r3_clr_ffvec", 32'(ffvec_a), 32'd0);
    check("r3_clr_vec",   32'(vec_a),   32'd0);
    n = 0;
    wait_done_a(5000, n);
    check("r3_err",   32'(err_a),   32'h800);
    check("r3_ffv",   32'(ffv_a),   32'd1);
    check("r3_ffvec", 32'(ffvec_a), 32'h000);
    check("r3_pass",  32'(pass_a),  32'd0);

    // Run 4: start re-pulsed at cycles 10 and 2000 while busy
    mode = 2'd0;
    pulse_start_a();
    n = 0;
    repeat (9) begin tick(); n++; end
    start_a = 1'b1;
    tick(); n++;
    start_a = 1'b0;
    check("r4_busy_at_10", 32'(busy_a), 32'd1);
    check("r4_vec_at_10",  32'(vec_a),  32'd5);
    repeat (1989) begin tick(); n++; end
    start_a = 1'b1;
    tick(); n++;
    start_a = 1'b0;
    check("r4_vec_at_2000", 32'(vec_a), 32'd1000);
    wait_done_a(5000, n);
    check("r4_cycles", 32'(n),      32'd4096);
    check("r4_pass",   32'(pass_a), 32'd1);
    check("r4_vec",    32'(vec_a),  32'h7FF);

    // Run 5: reset at cycle 1000 of a stuck-at-0 run, then a clean run
    mode = 2'd1;
    pulse_start_a();
    n = 0;
    repeat (1000) begin tick(); n++; end
    check("r5_ffv_pre_rst", 32'(ffv_a), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("r5_busy",  32'(busy_a),  32'd0);
    check("r5_done",  32'(done_a),  32'd0);
    check("r5_pass",  32'(pass_a),  32'd0);
    check("r5_vec",   32'(vec_a),   32'd0);
    check("r5_err",   32'(err_a),   32'd0);
    check("r5_ffv",   32'(ffv_a),   32'd0);
    check("r5_ffvec", 32'(ffvec_a), 32'd0);
    mode = 2'd0;
    pulse_start_a();
    n = 0;
    wait_done_a(5000, n);
    check("r5_cycles", 32'(n),      32'd4096);
    check("r5_pass",   32'(pass_a), 32'd1);
    check("r5_err2",   32'(err_a),  32'd0);

    check("busy_done_excl", 32'(excl_viol), 32'd0);

    // Run 6: pipelined DUT, SETTLE=3 (B) vs SETTLE=1 (C)
    start_bc = 1'b1;
    tick();
    start_bc = 1'b0;
    n  = 0;
    nb = 0;
    nc = 0;
    while (n < 9000) begin
      tick();
      n++;
      if (done_c && nc == 0) nc = n;
      if (done_b && nb == 0) nb = n;
      if (nb != 0) break;
    end
    check("r6_s1_cycles",  32'(nc),           32'd4096);
    check("r6_s1_err_nz",  32'(err_c != '0),  32'd1);
    check("r6_s1_pass",    32'(pass_c),       32'd0);
    check("r6_s3_cycles",  32'(nb),           32'd8192);
    check("r6_s3_pass",    32'(pass_b),       32'd1);
    check("r6_s3_err",     32'(err_b),        32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
